// File: rtl/min_queue_drain.sv
// ---------------------------------------------------------------------------
// min_queue_drain
//
// Drains records from a min-priority queue and serialises each record onto a
// byte stream. The FSM waits in IDLE until the queue presents a valid minimum.
// It then pops that record into a shift register in the same cycle. In SEND it
// emits the record MSB byte first over a valid/ready byte interface, then
// returns to IDLE.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high. While byte_valid is high and byte_ready is low,
// byte_data and byte_last stay constant. pop is a single-cycle command toward
// the queue; the queue drops the record on the edge where pop is high.
//
// Optional feature (compile-time macro MIN_QUEUE_DRAIN_ORDER_CHECK_EN):
//   When defined, the key of each popped record is compared with the key of
//   the previously popped record. order_err becomes sticky when a key
//   decreases. The first record after reset is never flagged. Equal keys are
//   legal. When undefined, order_err is tied low and no key storage exists.
//
// Parameters
//   REC_W  record width in bits (multiple of 8)
//   KEY_W  sort key width; key = record[REC_W-1 -: KEY_W]
//
// Ports
//   clk         rising-edge clock
//   rst_b       asynchronous reset, active HIGH despite the name
//   enable      drain permission, only looked at in IDLE
//   min_valid   queue output holds the current minimum
//   empty       queue holds no records
//   pop_record  minimum record from the queue
//   pop         pop command to the queue (combinational, IDLE only)
//   byte_data   serialised record byte
//   byte_valid  byte_data valid
//   byte_ready  downstream accepts the byte
//   byte_last   final byte of the current record
//   busy        high exactly while a record is in flight (SEND)
//   rec_count   records completely sent since reset (wraps at 2^16)
//   order_err   sticky key-ordering violation flag
// ---------------------------------------------------------------------------
module min_queue_drain #(
    parameter int REC_W = 48,
    parameter int KEY_W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             enable,
    input  logic             min_valid,
    input  logic             empty,
    input  logic [REC_W-1:0] pop_record,
    output logic             pop,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             byte_last,
    output logic             busy,
    output logic [15:0]      rec_count,
    output logic             order_err
);

    localparam int NBYTES = REC_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    // Catch unusable parameter combinations at elaboration time.
    if ((REC_W % 8) != 0 || REC_W < 8 || KEY_W < 1 || KEY_W > REC_W) begin : g_param_check
        $error("min_queue_drain: REC_W must be a non-zero multiple of 8 and 1 <= KEY_W <= REC_W");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_inc;
    logic [REC_W-1:0] shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [15:0]      count_q, count_d;
    logic             pop_go;
    logic             xfer;

    // Pop is gated by reset as well: the queue must never lose a record while
    // the drain is held in reset. Once reset falls, the first edge after that
    // is the earliest edge at which a pop can take effect.
    assign pop_go = !rst_b && (state_q == ST_IDLE) && enable && min_valid && !empty;
    assign xfer   = valid_q && byte_ready;
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        valid_d = valid_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_go) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    shift_d = pop_record;
                    valid_d = 1'b1;
                    last_d  = (LAST_IDX == '0);
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        shift_d = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        count_d = count_q + 16'd1;
                    end else begin
                        // The next byte always sits in the top byte lane, so
                        // byte_data is a fixed slice and needs no index mux.
                        idx_d   = idx_inc;
                        shift_d = shift_q << 8;
                        last_d  = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                shift_d = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign pop        = pop_go;
    assign byte_data  = shift_q[REC_W-1 -: 8];
    assign byte_valid = valid_q;
    assign byte_last  = last_q;
    assign busy       = (state_q == ST_SEND);
    assign rec_count  = count_q;

`ifdef MIN_QUEUE_DRAIN_ORDER_CHECK_EN
    logic [KEY_W-1:0] prev_key_q;
    logic             have_prev_q;
    logic             order_err_q;
    logic [KEY_W-1:0] pop_key;

    assign pop_key = pop_record[REC_W-1 -: KEY_W];

    // The key is checked on the pop edge itself. The previous key is then
    // replaced, so every record is compared only with its direct predecessor.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            prev_key_q  <= '0;
            have_prev_q <= 1'b0;
            order_err_q <= 1'b0;
        end else if (pop_go) begin
            prev_key_q  <= pop_key;
            have_prev_q <= 1'b1;
            if (have_prev_q && (pop_key < prev_key_q)) begin
                order_err_q <= 1'b1;
            end
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_min_queue_drain.sv
// ---------------------------------------------------------------------------
// tb_min_queue_drain
//
// Bench for min_queue_drain at default parameters. A monitor process runs at
// every falling clock edge. When pop is high, it pushes the expected
// {last, byte} sequence of the record being offered. On each accepted byte,
// it pops one entry and compares it with the DUT output. Scenario tasks drive
// inputs just after rising edges and check the timing and counters inline.
// ---------------------------------------------------------------------------
module tb_min_queue_drain;

    localparam int REC_W = 48;
    localparam int KEY_W = 16;
    localparam int NB    = REC_W / 8;

    logic             clk;
    logic             rst_b;
    logic             enable;
    logic             min_valid;
    logic             empty;
    logic [REC_W-1:0] pop_record;
    logic             pop;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic             byte_last;
    logic             busy;
    logic [15:0]      rec_count;
    logic             order_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];
    int         pop_cyc_q[$];
    int         cyc = 0;
    int         busy_cnt = 0;
    int         pop_cnt = 0;
    int         exp_count = 0;

    min_queue_drain #(
        .REC_W(REC_W),
        .KEY_W(KEY_W)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .enable    (enable),
        .min_valid (min_valid),
        .empty     (empty),
        .pop_record(pop_record),
        .pop       (pop),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_last (byte_last),
        .busy      (busy),
        .rec_count (rec_count),
        .order_err (order_err)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic mon_loop();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_b) begin
                if (busy) busy_cnt++;
                if (pop) begin
                    pop_cnt++;
                    pop_cyc_q.push_back(cyc);
                    for (int i = 0; i < NB; i++) begin
                        e[8]   = (i == NB - 1);
                        e[7:0] = pop_record[REC_W-1-8*i -: 8];
                        exp_q.push_back(e);
                    end
                end
                if (byte_valid && byte_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected_byte: got last=%b data=%h, required no byte", byte_last, byte_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({byte_last, byte_data} !== e) begin
                            n_err++;
                            $display("FAIL sb_byte: got last=%b data=%h, required last=%b data=%h",
                                     byte_last, byte_data, e[8], e[7:0]);
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic level, input int budget, input string what);
        int k;
        k = 0;
        while (busy !== level && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (busy !== level) begin
            n_err++;
            $display("FAIL %s: busy=%b after %0d cycles, required %b", what, busy, k, level);
        end
    endtask

    task automatic wait_byte(input logic [7:0] value, input int budget, input string what);
        int k;
        k = 0;
        while (!(byte_valid === 1'b1 && byte_data === value) && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (!(byte_valid === 1'b1 && byte_data === value)) begin
            n_err++;
            $display("FAIL %s: byte_data=%h valid=%b, required %h valid=1", what, byte_data, byte_valid, value);
        end
    endtask

    task automatic reset_dut();
        enable = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        tick();
        rst_b = 1'b0;
        exp_q.delete();
        pop_cyc_q.delete();
        exp_count = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_b      = 1'b0;
        enable     = 1'b0;
        min_valid  = 1'b0;
        empty      = 1'b1;
        byte_ready = 1'b1;
        pop_record = '0;
        #1;
        rst_b = 1'b1;
        #1;
        // No clock edge yet: these values come from the asynchronous reset.
        n_cmp++;
        if ({pop, byte_valid, byte_last, busy, order_err} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got pop/valid/last/busy/err=%b, required 00000",
                     {pop, byte_valid, byte_last, busy, order_err});
        end
        n_cmp++;
        if (byte_data !== 8'h00 || rec_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_data: got data=%h count=%0d, required 00 and 0", byte_data, rec_count);
        end
        enable     = 1'b1;
        min_valid  = 1'b1;
        empty      = 1'b0;
        pop_record = 48'h010203040506;
        #1;
        n_cmp++;
        if (pop !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pop_gate: got pop=%b, required 0", pop);
        end
        tick();
        tick();
        rst_b = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL release_no_early_start: got busy=%b, required 0", busy);
        end
        wait_busy(1'b1, 1, "release_first_edge_pop");
        enable = 1'b0;
        wait_busy(1'b0, 20, "release_record_done");
        exp_count++;
        n_cmp++;
        if (rec_count !== 16'(exp_count)) begin
            n_err++;
            $display("FAIL release_count: got %0d, required %0d", rec_count, exp_count);
        end
    endtask

    task automatic test_basic();
        reset_dut();
        pop_record = 48'hA1B2C3D4E5F6;
        min_valid  = 1'b1;
        empty      = 1'b0;
        byte_ready = 1'b1;
        busy_cnt   = 0;
        pop_cnt    = 0;
        enable     = 1'b1;
        wait_busy(1'b1, 5, "basic_start");
        enable = 1'b0;
        n_cmp++;
        if (byte_data !== 8'hA1) begin
            n_err++;
            $display("FAIL basic_first_byte: got %h, required a1", byte_data);
        end
        wait_busy(1'b0, 20, "basic_done");
        exp_count++;
        n_cmp++;
        if (pop_cnt !== 1 || busy_cnt !== 6) begin
            n_err++;
            $display("FAIL basic_timing: got pops=%0d busy_cycles=%0d, required 1 and 6", pop_cnt, busy_cnt);
        end
        n_cmp++;
        if (rec_count !== 16'd1) begin
            n_err++;
            $display("FAIL basic_count: got %0d, required 1", rec_count);
        end
    endtask

    task automatic test_backpressure();
        pop_record = 48'hA1B2C3D4E5F6;
        busy_cnt   = 0;
        enable     = 1'b1;
        wait_busy(1'b1, 5, "bp_start");
        enable = 1'b0;
        wait_byte(8'hC3, 10, "bp_reach_c3");
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (byte_valid !== 1'b1 || byte_data !== 8'hC3 || byte_last !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got valid=%b data=%h last=%b, required 1 c3 0",
                         i, byte_valid, byte_data, byte_last);
            end
            tick();
        end
        byte_ready = 1'b1;
        wait_busy(1'b0, 20, "bp_done");
        exp_count++;
        n_cmp++;
        if (busy_cnt !== 9) begin
            n_err++;
            $display("FAIL bp_duration: got %0d cycles, required 9", busy_cnt);
        end
        n_cmp++;
        if (rec_count !== 16'(exp_count)) begin
            n_err++;
            $display("FAIL bp_count: got %0d, required %0d", rec_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        int          low_cnt;
        bit          done;
        reset_dut();
        low_cnt = 0;
        done    = 1'b0;
        r = {$urandom(), $urandom()};
        pop_record = r[47:0];
        min_valid  = 1'b1;
        empty      = 1'b0;
        enable     = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (pop_cyc_q.size() >= 1 && pop_cyc_q.size() < 3 && !busy) low_cnt++;
            if (busy) begin
                r = {$urandom(), $urandom()};
                pop_record = r[47:0];
            end
            if (pop_cyc_q.size() >= 3) begin
                enable = 1'b0;
                done   = 1'b1;
            end
        end
        wait_busy(1'b0, 20, "b2b_done");
        exp_count += 3;
        n_cmp++;
        if (!done || pop_cyc_q.size() != 3) begin
            n_err++;
            $display("FAIL b2b_pops: got %0d pops, required 3", pop_cyc_q.size());
        end else begin
            n_cmp++;
            if (pop_cyc_q[1] - pop_cyc_q[0] != 7 || pop_cyc_q[2] - pop_cyc_q[1] != 7) begin
                n_err++;
                $display("FAIL b2b_period: got %0d and %0d, required 7 and 7",
                         pop_cyc_q[1] - pop_cyc_q[0], pop_cyc_q[2] - pop_cyc_q[1]);
            end
        end
        n_cmp++;
        if (low_cnt != 2) begin
            n_err++;
            $display("FAIL b2b_idle_gap: got %0d idle cycles, required 2 (one per gap)", low_cnt);
        end
        n_cmp++;
        if (rec_count !== 16'd3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d, required 3", rec_count);
        end
    endtask

    task automatic test_enable_drop();
        pop_record = 48'hA1B2C3D4E5F6;
        min_valid  = 1'b1;
        empty      = 1'b0;
        enable     = 1'b1;
        wait_busy(1'b1, 5, "en_drop_start");
        wait_byte(8'hB2, 5, "en_drop_reach_b2");
        enable = 1'b0;
        wait_busy(1'b0, 20, "en_drop_done");
        exp_count++;
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++;
        if (pop_cnt != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL en_drop_no_pop: got pops=%0d busy=%b, required 0 and 0", pop_cnt, busy);
        end
        n_cmp++;
        if (rec_count !== 16'(exp_count)) begin
            n_err++;
            $display("FAIL en_drop_count: got %0d, required %0d", rec_count, exp_count);
        end
    endtask

    task automatic test_gating();
        int base;
        base    = exp_count;
        pop_cnt = 0;
        enable = 1'b1; min_valid = 1'b1; empty = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (pop_cnt != 0) begin
            n_err++;
            $display("FAIL gate_empty: got %0d pops, required 0", pop_cnt);
        end
        min_valid = 1'b0; empty = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (pop_cnt != 0) begin
            n_err++;
            $display("FAIL gate_min_valid: got %0d pops, required 0", pop_cnt);
        end
        enable = 1'b0; min_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (pop_cnt != 0 || rec_count !== 16'(base)) begin
            n_err++;
            $display("FAIL gate_enable: got pops=%0d count=%0d, required 0 and %0d", pop_cnt, rec_count, base);
        end
    endtask

    task automatic test_reset_mid();
        pop_record = 48'hA1B2C3D4E5F6;
        min_valid  = 1'b1;
        empty      = 1'b0;
        enable     = 1'b1;
        wait_busy(1'b1, 5, "rmid_start");
        wait_byte(8'hD4, 10, "rmid_reach_d4");
        #2;
        rst_b = 1'b1;
        #1;
        n_cmp++;
        if ({pop, byte_valid, byte_last, busy} !== 4'b0 || byte_data !== 8'h00 || rec_count !== 16'd0) begin
            n_err++;
            $display("FAIL rmid_async: got pop/valid/last/busy=%b data=%h count=%0d, required 0000 00 0",
                     {pop, byte_valid, byte_last, busy}, byte_data, rec_count);
        end
        exp_q.delete();
        exp_count = 0;
        tick();
        tick();
        pop_record = 48'h5A6B7C8D9EAF;
        rst_b = 1'b0;
        wait_busy(1'b1, 3, "rmid_restart");
        enable = 1'b0;
        n_cmp++;
        if (byte_data !== 8'h5A) begin
            n_err++;
            $display("FAIL rmid_byte0: got %h, required 5a", byte_data);
        end
        wait_busy(1'b0, 20, "rmid_done");
        exp_count++;
        n_cmp++;
        if (rec_count !== 16'd1) begin
            n_err++;
            $display("FAIL rmid_count: got %0d, required 1", rec_count);
        end
    endtask

    task automatic test_order();
        logic [15:0] keys[5];
        logic        exp_err[5];
        keys = '{16'h0010, 16'h0010, 16'h0008, 16'hFFFF, 16'hFFFF};
`ifdef MIN_QUEUE_DRAIN_ORDER_CHECK_EN
        exp_err = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset_dut();
        min_valid = 1'b1;
        empty     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pop_record = {keys[i], 32'h0BAD_F00D};
            enable = 1'b1;
            wait_busy(1'b1, 5, "order_start");
            enable = 1'b0;
            n_cmp++;
            if (order_err !== exp_err[i]) begin
                n_err++;
                $display("FAIL order_err_%0d: got %b, required %b", i, order_err, exp_err[i]);
            end
            wait_busy(1'b0, 20, "order_done");
            exp_count++;
        end
        n_cmp++;
        if (rec_count !== 16'(exp_count)) begin
            n_err++;
            $display("FAIL order_count: got %0d, required %0d", rec_count, exp_count);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        fork
            mon_loop();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_enable_drop();
        test_gating();
        test_reset_mid();
        test_order();
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d undelivered bytes, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/min_queue_drain.md
MIN_QUEUE_DRAIN -- requirements
Module: min_queue_drain

Interface
REQ-001 Parameter: REC_W, 48, record width in bits; always a multiple of 8.
REQ-002 Parameter: KEY_W, 16, sort key width; key is record bits [REC_W-1 : REC_W-KEY_W].
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst_b  in  1  reset; asynchronous, active-high.
REQ-005 Port: enable  in  1  drain permission; sampled only in IDLE.
REQ-006 Port: min_valid  in  1  queue pop_record holds the current minimum.
REQ-007 Port: empty  in  1  queue holds no records.
REQ-008 Port: pop_record  in  REC_W  minimum record from queue.
REQ-009 Port: pop  out  1  pop command to queue; one-cycle pulse.
REQ-010 Port: byte_data  out  8  serialized record byte.
REQ-011 Port: byte_valid  out  1  byte_data valid.
REQ-012 Port: byte_ready  in  1  downstream accepts byte.
REQ-013 Port: byte_last  out  1  final byte of current record.
REQ-014 Port: busy  out  1  record in flight (state != IDLE).
REQ-015 Port: rec_count  out  16  records fully sent since reset.
REQ-016 Port: order_err  out  1  sticky ordering violation flag.

Function
REQ-017 FSM states IDLE, SEND; reset state IDLE.
REQ-018 IDLE: pop = enable && min_valid && !empty, combinational, asserted only in IDLE.
REQ-019 Pop cycle: pop_record captured into the shift register on the same clk edge; FSM -> SEND; byte index cleared to 0.
REQ-020 SEND: byte_valid = 1; byte_data = captured record byte at the current index, MSB byte first (index 0 = bits [REC_W-1:REC_W-8]).
REQ-021 byte_valid/byte_ready handshake: index advances only when both high; byte_data and byte_last stable while byte_valid && !byte_ready.
REQ-022 byte_last = 1 only when index = REC_W/8-1 in SEND.
REQ-023 Handshake on last byte: FSM -> IDLE; rec_count += 1 (mod 2^16, wraps 65535 -> 0).
REQ-024 Minimum record period 1 + REC_W/8 cycles (7 at default); no back-to-back pops; next pop no earlier than the cycle after the last-byte handshake.
REQ-025 enable deasserted in SEND: current record completes; no further pop issued.
REQ-026 min_valid or empty changing during SEND: ignored.
REQ-027 min_valid=1 with empty=1: no pop.
REQ-028 busy = 1 exactly in SEND.

Reset
REQ-029 rst_b high: immediately, without clk, state=IDLE, index=0, shift register=0, rec_count=0, order_err=0, byte_valid=0, byte_last=0, byte_data=0, pop=0.
REQ-030 Reset mid-record: in-flight record discarded; it is not re-sent and not counted.
REQ-031 First pop no earlier than the first rising clk edge after rst_b falls.

Configuration
REQ-032 Macro MIN_QUEUE_DRAIN_ORDER_CHECK_EN defined: key of each popped record is compared with the key of the previous popped record; if new key < previous key, order_err is set on the pop edge and held until reset; the first record after reset is not checked; equal keys are legal.
REQ-033 Macro undefined: no key storage or comparator; order_err tied 0; port list unchanged.

Verification
REQ-034 Reset, enable=1, min_valid=1, empty=0, pop_record=48'hA1B2C3D4E5F6, byte_ready=1 -> pop one cycle; bytes A1,B2,C3,D4,E5,F6 on 6 consecutive cycles; byte_last on F6; rec_count=1.
REQ-035 Same record, byte_ready low for 3 cycles at byte C3 -> C3 held stable 3 cycles with byte_valid=1, then D4..F6; total 9 cycles from pop to IDLE.
REQ-036 Continuous min_valid=1, 3 records, byte_ready=1 -> pops exactly 7 cycles apart; rec_count=3; busy low for exactly 1 cycle between records.
REQ-037 enable dropped during byte B2 -> record completes to F6; no further pop while enable=0.
REQ-038 rst_b asserted at byte D4 -> outputs zero asynchronously; after release with enable=1, the next record starts at its byte 0; rec_count=0.
REQ-039 ORDER_CHECK_EN defined: keys 16'h0010, 16'h0010, 16'h0008 -> order_err=0 after the first two, 1 on the third pop edge, stays 1 after later keys 16'hFFFF; macro undefined -> order_err=0 throughout.
